// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch PC unit: FSM state encoding and
// default reset/trap vectors.
package if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] IF_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/if_pc_incr.sv
// Sequential next-PC adder; wraps modulo 2^XLEN with no carry out.
module if_pc_incr #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus
);

  assign pc_plus = pc + XLEN'(STEP);

endmodule

// File: rtl/if_pc_unit.sv
// Fetch PC generator: IDLE/RUN/BUBBLE FSM with valid/ready handshake, redirect
// handling with misalignment trap, and a saturating accepted-fetch counter.
module if_pc_unit
  import if_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              STEP         = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(IF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(IF_TRAP_VECTOR),
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pc_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus,
  output logic             pc_valid,
  output logic             misalign_trap,
  output logic [CNT_W-1:0] fetch_count
);

  // Low address bits that must be zero; STEP=1 yields an all-zero mask.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  if_state_e        state_r;
  if_state_e        state_nxt_s;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pc_plus_s;
  logic [XLEN-1:0]  redir_pc_s;
  logic             pc_valid_r;
  logic             misalign_trap_r;
  logic [CNT_W-1:0] fetch_count_r;
  logic             misalign_s;
  logic             transfer_s;

  if_pc_incr #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_incr (
    .pc      (pc_r),
    .pc_plus (pc_plus_s)
  );

  assign misalign_s = (redirect_target & ALIGN_MASK) != '0;
  assign redir_pc_s = misalign_s ? TRAP_VECTOR : redirect_target;
  assign transfer_s = pc_valid_r & pc_ready;

  // Next-state logic; a redirect always wins over enable.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (redirect_valid) state_nxt_s = ST_IDLE;
        else if (en)        state_nxt_s = ST_RUN;
        else                state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (redirect_valid) state_nxt_s = ST_BUBBLE;
        else if (!en)       state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_RUN;
      end
      ST_BUBBLE: begin
        if (redirect_valid) state_nxt_s = ST_BUBBLE;
        else if (en)        state_nxt_s = ST_RUN;
        else                state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, PC, valid, trap pulse and fetch counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      pc_r            <= RESET_VECTOR;
      pc_valid_r      <= 1'b0;
      misalign_trap_r <= 1'b0;
      fetch_count_r   <= '0;
    end else begin
      state_r         <= state_nxt_s;
      pc_valid_r      <= (state_nxt_s == ST_RUN);
      misalign_trap_r <= redirect_valid & misalign_s;
      if (redirect_valid) begin
        pc_r <= redir_pc_s;
      end else if (transfer_s) begin
        pc_r <= pc_plus_s;
      end else begin
        pc_r <= pc_r;
      end
      // A transfer squashed by a same-cycle redirect is not counted.
      if (transfer_s && !redirect_valid && (fetch_count_r != '1)) begin
        fetch_count_r <= fetch_count_r + CNT_W'(1);
      end else begin
        fetch_count_r <= fetch_count_r;
      end
    end
  end

  assign pc            = pc_r;
  assign pc_plus       = pc_plus_s;
  assign pc_valid      = pc_valid_r;
  assign misalign_trap = misalign_trap_r;
  assign fetch_count   = fetch_count_r;

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed-vector bench for if_pc_unit (default parameters) plus a second
// instance with STEP=1, CNT_W=2 for counter saturation and no-misalign behaviour.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        rst, en, pc_ready, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc, pc_plus, fetch_count;
  logic        pc_valid, misalign_trap;

  logic        b_rst, b_en, b_ready, b_rv;
  logic [31:0] b_tgt;
  logic [31:0] b_pc, b_pc_plus;
  logic        b_valid, b_trap;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .pc_ready        (pc_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc_plus         (pc_plus),
    .pc_valid        (pc_valid),
    .misalign_trap   (misalign_trap),
    .fetch_count     (fetch_count)
  );

  if_pc_unit #(.STEP(1), .CNT_W(2)) dut_b (
    .clk             (clk),
    .rst             (b_rst),
    .en              (b_en),
    .pc_ready        (b_ready),
    .redirect_valid  (b_rv),
    .redirect_target (b_tgt),
    .pc              (b_pc),
    .pc_plus         (b_pc_plus),
    .pc_valid        (b_valid),
    .misalign_trap   (b_trap),
    .fetch_count     (b_cnt)
  );

  typedef struct {
    logic        rst, en, rdy, rv;
    logic [31:0] tgt;
    logic [31:0] pc, plus, cnt;
    logic        valid, trap;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic y, input logic v,
                     input logic [31:0] t, input logic [31:0] p, input logic va,
                     input logic tr, input logic [31:0] c, input logic [31:0] pl);
    vec_t x;
    x.rst = r; x.en = e; x.rdy = y; x.rv = v; x.tgt = t;
    x.pc = p; x.valid = va; x.trap = tr; x.cnt = c; x.plus = pl;
    vq.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pc_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0;
    b_rst = 1'b1; b_en = 1'b0; b_ready = 1'b0; b_rv = 1'b0; b_tgt = 32'h0;

    //  rst  en   rdy  rv   target        pc            valid trap cnt    pc_plus
    add(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'd0,32'h4);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'd0,32'h4);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h4,        1'b1,1'b0,32'd1,32'h8);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h8,        1'b1,1'b0,32'd2,32'hC);
    add(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h8,        1'b1,1'b0,32'd2,32'hC);
    add(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h8,        1'b1,1'b0,32'd2,32'hC);
    add(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h8,        1'b1,1'b0,32'd2,32'hC);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'hC,        1'b1,1'b0,32'd3,32'h10);
    add(1'b0,1'b1,1'b1,1'b1,32'h100,      32'h100,      1'b0,1'b0,32'd3,32'h104);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h100,      1'b1,1'b0,32'd3,32'h104);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h104,      1'b1,1'b0,32'd4,32'h108);
    add(1'b0,1'b1,1'b1,1'b1,32'h102,      32'h80,       1'b0,1'b1,32'd4,32'h84);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h80,       1'b1,1'b0,32'd4,32'h84);
    add(1'b0,1'b1,1'b1,1'b1,32'h200,      32'h200,      1'b0,1'b0,32'd4,32'h204);
    add(1'b0,1'b1,1'b1,1'b1,32'h300,      32'h300,      1'b0,1'b0,32'd4,32'h304);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h300,      1'b1,1'b0,32'd4,32'h304);
    add(1'b0,1'b1,1'b1,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,1'b0,1'b0,32'd4,32'h0);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'hFFFF_FFFC,1'b1,1'b0,32'd4,32'h0);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'd5,32'h4);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'd5,32'h4);
    add(1'b0,1'b0,1'b0,1'b1,32'h40,       32'h40,       1'b0,1'b0,32'd5,32'h44);
    add(1'b0,1'b0,1'b0,1'b1,32'h41,       32'h80,       1'b0,1'b1,32'd5,32'h84);
    add(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h80,       1'b1,1'b0,32'd5,32'h84);
    add(1'b0,1'b1,1'b0,1'b1,32'h40,       32'h40,       1'b0,1'b0,32'd5,32'h44);
    add(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h40,       1'b1,1'b0,32'd5,32'h44);
    add(1'b1,1'b1,1'b1,1'b1,32'h102,      32'h0,        1'b0,1'b0,32'd0,32'h4);
    add(1'b0,1'b1,1'b1,1'b1,32'h100,      32'h100,      1'b0,1'b0,32'd0,32'h104);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h100,      1'b1,1'b0,32'd0,32'h104);
    add(1'b0,1'b1,1'b1,1'b1,32'h200,      32'h200,      1'b0,1'b0,32'd0,32'h204);
    add(1'b0,1'b1,1'b1,1'b0,32'h0,        32'h200,      1'b1,1'b0,32'd0,32'h204);
    add(1'b1,1'b1,1'b1,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'd0,32'h4);
    add(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'd0,32'h4);
    add(1'b0,1'b0,1'b1,1'b0,32'h0,        32'h4,        1'b0,1'b0,32'd1,32'h8);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; en = vq[i].en; pc_ready = vq[i].rdy;
      redirect_valid = vq[i].rv; redirect_target = vq[i].tgt;
      @(posedge clk); #1;
      chk("pc",          i, pc,                  vq[i].pc);
      chk("pc_valid",    i, {31'd0, pc_valid},   {31'd0, vq[i].valid});
      chk("trap",        i, {31'd0, misalign_trap}, {31'd0, vq[i].trap});
      chk("fetch_count", i, fetch_count,         vq[i].cnt);
      chk("pc_plus",     i, pc_plus,             vq[i].plus);
    end

    // STEP=1, CNT_W=2: counter saturates at 3; odd targets never trap.
    b_rst = 1'b1;
    @(posedge clk); #1;
    chk("b_reset_pc", 100, b_pc, 32'h0);
    b_rst = 1'b0; b_en = 1'b1; b_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    chk("b_pc_after_4", 101, b_pc, 32'h4);
    chk("b_cnt_sat",    102, {30'd0, b_cnt}, 32'd3);
    chk("b_pc_plus",    103, b_pc_plus, 32'h5);
    b_rv = 1'b1; b_tgt = 32'h3;
    @(posedge clk); #1;
    b_rv = 1'b0;
    chk("b_odd_target", 104, b_pc, 32'h3);
    chk("b_no_trap",    105, {31'd0, b_trap}, 32'd0);
    chk("b_cnt_hold",   106, {30'd0, b_cnt}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_pc_unit.md
IF_PC_UNIT -- requirements
Module: if_pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width.
REQ-002 SHALL have parameter STEP, default 4: sequential increment in bytes; power of two, at least 1.
REQ-003 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset.
REQ-004 SHALL have parameter TRAP_VECTOR, default 32'h0000_0080: PC value loaded on a misaligned redirect.
REQ-005 SHALL have parameter CNT_W, default 32: fetch counter width.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port en, input, 1 bit: fetch enable.
REQ-009 SHALL have port pc_ready, input, 1 bit: downstream (IF/ID) accepts the current PC.
REQ-010 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-011 SHALL have port redirect_target, input, XLEN bits: redirect address.
REQ-012 SHALL have port pc, output, XLEN bits: current fetch PC (registered).
REQ-013 SHALL have port pc_plus, output, XLEN bits: pc + STEP (combinational from pc).
REQ-014 SHALL have port pc_valid, output, 1 bit: pc is a valid fetch address.
REQ-015 SHALL have port misalign_trap, output, 1 bit: registered one-cycle pulse on a misaligned redirect.
REQ-016 SHALL have port fetch_count, output, CNT_W bits: count of accepted fetches.

Function
REQ-017 SHALL implement a three-state FSM: IDLE (pc_valid=0), RUN (pc_valid=1), BUBBLE (pc_valid=0).
REQ-018 SHALL define transfer as pc_valid && pc_ready in the same cycle.
REQ-019 SHALL make the FSM transitions as follows:
- IDLE -> RUN when en=1.
- RUN -> IDLE when en=0 and no redirect.
- Any state -> BUBBLE on redirect_valid, except from IDLE.
- BUBBLE -> RUN when en=1, else -> IDLE.
REQ-020 SHALL update pc with this priority: rst > redirect_valid > transfer (pc <= pc_plus) > hold.
REQ-021 SHALL make redirect_valid in IDLE load pc and remain in IDLE.
REQ-022 SHALL make redirect_valid in BUBBLE load the new target and stay in BUBBLE one further cycle (latest redirect wins).
REQ-023 SHALL discard a transfer coinciding with redirect_valid: it is not counted and pc takes the target.
REQ-024 SHALL treat a redirect as misaligned when redirect_target[log2(STEP)-1:0] != 0 (never when STEP=1).
REQ-025 SHALL, on a misaligned redirect, load pc with TRAP_VECTOR instead of the target and assert misalign_trap for exactly the next cycle.
REQ-026 SHALL compute pc_plus = (pc + STEP) mod 2^XLEN, wrapping silently with no flag.
REQ-027 SHALL hold pc and pc_valid stable while pc_valid=1 and pc_ready=0, absent a redirect.
REQ-028 SHALL increment fetch_count by 1 per counted transfer, saturating at all-ones.
REQ-029 SHALL give a redirect a latency of one cycle to the pc update and two cycles to the first pc_valid=1 at the new PC.

Reset
REQ-030 SHALL, while rst=1, set at the next edge: pc=RESET_VECTOR, FSM=IDLE, pc_valid=0, misalign_trap=0, fetch_count=0.
REQ-031 SHALL let rst override en, redirect_valid and any transfer in the same cycle, including mid-redirect or mid-BUBBLE.
REQ-032 SHALL make pc_plus read RESET_VECTOR+STEP during reset.

Structure
REQ-033 SHALL place the FSM state encoding (IDLE/RUN/BUBBLE) and the default RESET_VECTOR/TRAP_VECTOR constants in shared package if_pkg.
REQ-034 SHALL instantiate one sub-module, if_pc_incr (parametrised XLEN, STEP), producing pc_plus from pc.
REQ-035 SHALL register all outputs except pc_plus.

Verification (XLEN=32, STEP=4, defaults)
REQ-036 SHALL cover: rst=1 then en=1, pc_ready=1 for 4 cycles -> pc 0x0 (valid=0), then 0x0, 0x4, 0x8 valid; fetch_count=3 after 3 transfers.
REQ-037 SHALL cover: pc_ready=0 for 3 cycles at pc=0x8 -> pc=0x8, pc_valid=1 held, fetch_count unchanged.
REQ-038 SHALL cover: redirect to 0x100 with pc_ready=1 at pc=0xC -> next cycle pc=0x100, valid=0; the cycle after, valid=1; count not incremented for 0xC.
REQ-039 SHALL cover: redirect to 0x102 -> next cycle pc=0x80, misalign_trap=1 for one cycle only.
REQ-040 SHALL cover: redirect to 0xFFFF_FFFC, then transfer -> pc=0x0000_0000, pc_plus=0x4.
REQ-041 SHALL cover: rst=1 asserted in RUN at pc=0x40 together with redirect_valid -> pc=0x0, pc_valid=0, fetch_count=0, misalign_trap=0.
